// File: rtl/adbg_jsp_16550_pkg.sv
// -----------------------------------------------------------------------------
// adbg_jsp_16550_pkg
// Shared definitions for the JTAG Serial Port 16550-style APB bus interface:
// register indices, IIR codes, the FCR receive-trigger encoding and packed
// views of the IER and LSR registers.
// -----------------------------------------------------------------------------
package adbg_jsp_16550_pkg;

   // Register indices (PADDR)
   localparam logic [2:0] ADDR_RBR_THR = 3'd0;  // DLL when DLAB=1
   localparam logic [2:0] ADDR_IER     = 3'd1;  // DLM when DLAB=1
   localparam logic [2:0] ADDR_IIR_FCR = 3'd2;
   localparam logic [2:0] ADDR_LCR     = 3'd3;
   localparam logic [2:0] ADDR_MCR     = 3'd4;
   localparam logic [2:0] ADDR_LSR     = 3'd5;
   localparam logic [2:0] ADDR_MSR     = 3'd6;
   localparam logic [2:0] ADDR_SCR     = 3'd7;

   // IIR codes; bits 7:6 report FIFOs enabled
   localparam logic [7:0] IIR_RLS  = 8'hC6;
   localparam logic [7:0] IIR_RDA  = 8'hC4;
   localparam logic [7:0] IIR_THRE = 8'hC2;
   localparam logic [7:0] IIR_NONE = 8'hC1;

   localparam logic [7:0] MSR_VALUE = 8'h0B;

   // FCR[7:6] receive trigger selection
   typedef enum logic [1:0] {
      TRIG_ONE     = 2'b00,
      TRIG_QUARTER = 2'b01,
      TRIG_HALF    = 2'b10,
      TRIG_NEAR    = 2'b11
   } fcr_trig_e;

   typedef struct packed {
      logic elsi;
      logic etbei;
      logic erbfi;
   } ier_struct;

   typedef struct packed {
      logic rsvd7;
      logic temt;
      logic thre;
      logic bi;
      logic fe;
      logic pe;
      logic oe;
      logic dr;
   } lsr_struct;

   // Receive-FIFO fill level at which the data-available interrupt fires
   function automatic int trig_level(input fcr_trig_e t, input int depth);
      case (t)
         TRIG_ONE:     return 1;
         TRIG_QUARTER: return depth / 4;
         TRIG_HALF:    return depth / 2;
         default:      return depth - 2;
      endcase
   endfunction

endpackage

// File: rtl/adbg_jsp_fifo.sv
// -----------------------------------------------------------------------------
// adbg_jsp_fifo
// Byte FIFO with registered occupancy count. Push is ignored when full, pop is
// ignored when empty, and a synchronous clear overrides both.
// Ports:
//   PCLK, rst_i       clock, asynchronous active-high reset
//   clr               synchronous flush
//   push, din         write strobe and data
//   pop               advance the head
//   dout              current head (stale when empty)
//   count             occupied entries (0..DEPTH)
//   full, empty       decoded from count
// -----------------------------------------------------------------------------
module adbg_jsp_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     PCLK,
   input  logic                     rst_i,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge PCLK or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries no reset; validity is tracked by count
   always_ff @(posedge PCLK) begin
      if (do_push && !clr) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/adbg_jsp_apb_biu_p.sv
// -----------------------------------------------------------------------------
// adbg_jsp_apb_biu_p
// JTAG Serial Port bus interface unit: two byte FIFOs between the JTAG-side
// engine (valid/ready) and an APB slave emulating a 16550 UART with FIFOs on.
// Ports:
//   PCLK, rst_i                     clock, asynchronous active-high reset
//   jrx_valid_i/jrx_data_i/jrx_ready_o  JTAG -> RX FIFO byte handshake
//   jtx_valid_o/jtx_data_o/jtx_ready_i  TX FIFO -> JTAG byte handshake
//   rx_free_o, tx_avail_o           free RX entries, occupied TX entries
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR  APB slave
//   int_o                           interrupt pending (IIR[0]=0)
// -----------------------------------------------------------------------------
module adbg_jsp_apb_biu_p #(
   parameter int DEPTH = 8
) (
   input  logic                     PCLK,
   input  logic                     rst_i,
   input  logic                     jrx_valid_i,
   input  logic [7:0]               jrx_data_i,
   output logic                     jrx_ready_o,
   output logic                     jtx_valid_o,
   output logic [7:0]               jtx_data_o,
   input  logic                     jtx_ready_i,
   output logic [$clog2(DEPTH):0]   rx_free_o,
   output logic [$clog2(DEPTH):0]   tx_avail_o,
   input  logic                     PSEL,
   input  logic                     PENABLE,
   input  logic                     PWRITE,
   input  logic [2:0]               PADDR,
   input  logic [7:0]               PWDATA,
   output logic [7:0]               PRDATA,
   output logic                     PREADY,
   output logic                     PSLVERR,
   output logic                     int_o
);

   import adbg_jsp_16550_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic        acc, rd_acc, wr_acc, dlab;
   logic        thr_wr, rbr_rd, fcr_wr, iir_rd, lsr_rd;
   ier_struct   ier;
   fcr_trig_e   trigger;
   logic [7:0]  lcr, scr, dll, dlm;
   logic        oe, thr_arm, arm_set;
   logic [7:0]  iir;
   lsr_struct   lsr;
   int          rx_lvl;

   logic          rx_clr, rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]    rx_head;
   logic [CW-1:0] rx_count;
   logic          tx_clr, tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0]    tx_head;
   logic [CW-1:0] tx_count, tx_after;

   assign acc    = PSEL & PENABLE;
   assign rd_acc = acc & ~PWRITE;
   assign wr_acc = acc & PWRITE;
   assign dlab   = lcr[7];

   assign thr_wr = wr_acc & (PADDR == ADDR_RBR_THR) & ~dlab;
   assign rbr_rd = rd_acc & (PADDR == ADDR_RBR_THR) & ~dlab;
   assign fcr_wr = wr_acc & (PADDR == ADDR_IIR_FCR);
   assign iir_rd = rd_acc & (PADDR == ADDR_IIR_FCR);
   assign lsr_rd = rd_acc & (PADDR == ADDR_LSR);

   assign rx_clr  = fcr_wr & PWDATA[1];
   assign tx_clr  = fcr_wr & PWDATA[2];
   assign rx_push = jrx_valid_i & ~rx_full;
   assign rx_pop  = rbr_rd & ~rx_empty;
   assign tx_push = thr_wr & ~tx_full;
   assign tx_pop  = jtx_ready_i & ~tx_empty;

   adbg_jsp_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
      .PCLK  (PCLK),
      .rst_i (rst_i),
      .clr   (rx_clr),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (jrx_data_i),
      .dout  (rx_head),
      .count (rx_count),
      .full  (rx_full),
      .empty (rx_empty)
   );

   adbg_jsp_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
      .PCLK  (PCLK),
      .rst_i (rst_i),
      .clr   (tx_clr),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (PWDATA),
      .dout  (tx_head),
      .count (tx_count),
      .full  (tx_full),
      .empty (tx_empty)
   );

   // TX occupancy after this edge, ignoring a clear (clear wins separately)
   assign tx_after = tx_count + CW'(tx_push) - CW'(tx_pop);
   assign arm_set  = (tx_pop & (tx_after == '0)) |
                     (thr_wr & (tx_after != CW'(DEPTH)));

   always_ff @(posedge PCLK or posedge rst_i) begin
      if (rst_i) begin
         ier     <= '0;
         lcr     <= '0;
         scr     <= '0;
         dll     <= '0;
         dlm     <= '0;
         oe      <= 1'b0;
         thr_arm <= 1'b0;
         trigger <= TRIG_ONE;
      end else begin
         if (wr_acc) begin
            case (PADDR)
               ADDR_RBR_THR: if (dlab) dll <= PWDATA;
               ADDR_IER:     if (dlab) dlm <= PWDATA;
                             else      ier <= ier_struct'(PWDATA[2:0]);
               ADDR_IIR_FCR: trigger <= fcr_trig_e'(PWDATA[7:6]);
               ADDR_LCR:     lcr <= PWDATA;
               ADDR_SCR:     scr <= PWDATA;
               default:      ;
            endcase
         end
         // A dropped THR byte and an LSR read never coincide (write vs read)
         if (thr_wr && tx_full && !tx_pop) oe <= 1'b1;
         else if (thr_wr && tx_full)       oe <= 1'b1;
         else if (lsr_rd)                  oe <= 1'b0;
         // Flush beats a new arm event; a new arm event beats the IIR-read ack
         if (tx_clr)                             thr_arm <= 1'b0;
         else if (arm_set)                       thr_arm <= 1'b1;
         else if (iir_rd && (iir == IIR_THRE))   thr_arm <= 1'b0;
      end
   end

   assign rx_lvl = trig_level(trigger, DEPTH);

   always_comb begin
      lsr       = '0;
      lsr.temt  = ~tx_full;
      lsr.thre  = ~tx_full;
      lsr.oe    = oe;
      lsr.dr    = ~rx_empty;
   end

   always_comb begin
      if (oe && ier.elsi)                                 iir = IIR_RLS;
      else if ((int'(rx_count) >= rx_lvl) && ier.erbfi)   iir = IIR_RDA;
      else if (thr_arm && !tx_full && ier.etbei)          iir = IIR_THRE;
      else                                                iir = IIR_NONE;
   end

   always_comb begin
      PRDATA = 8'h00;
      case (PADDR)
         ADDR_RBR_THR: PRDATA = dlab ? dll : (rx_empty ? 8'h00 : rx_head);
         ADDR_IER:     PRDATA = dlab ? dlm : {5'b0, ier};
         ADDR_IIR_FCR: PRDATA = iir;
         ADDR_LCR:     PRDATA = lcr;
         ADDR_MCR:     PRDATA = 8'h00;
         ADDR_LSR:     PRDATA = lsr;
         ADDR_MSR:     PRDATA = MSR_VALUE;
         default:      PRDATA = scr;
      endcase
   end

   assign jrx_ready_o = ~rx_full;
   assign jtx_valid_o = ~tx_empty;
   assign jtx_data_o  = tx_empty ? 8'h00 : tx_head;
   assign rx_free_o   = CW'(DEPTH) - rx_count;
   assign tx_avail_o  = tx_count;
   assign int_o       = ~iir[0];
   assign PREADY      = 1'b1;
   assign PSLVERR     = 1'b0;

endmodule

// File: tb/tb_adbg_jsp_apb_biu_p.sv
module tb_adbg_jsp_apb_biu_p;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          PCLK = 1'b0;
   logic          rst_i;
   logic          jrx_valid_i;
   logic [7:0]    jrx_data_i;
   logic          jrx_ready_o;
   logic          jtx_valid_o;
   logic [7:0]    jtx_data_o;
   logic          jtx_ready_i;
   logic [CW-1:0] rx_free_o;
   logic [CW-1:0] tx_avail_o;
   logic          PSEL, PENABLE, PWRITE;
   logic [2:0]    PADDR;
   logic [7:0]    PWDATA;
   logic [7:0]    PRDATA;
   logic          PREADY, PSLVERR;
   logic          int_o;

   adbg_jsp_apb_biu_p #(.DEPTH(DEPTH)) dut (
      .PCLK(PCLK), .rst_i(rst_i),
      .jrx_valid_i(jrx_valid_i), .jrx_data_i(jrx_data_i), .jrx_ready_o(jrx_ready_o),
      .jtx_valid_o(jtx_valid_o), .jtx_data_o(jtx_data_o), .jtx_ready_i(jtx_ready_i),
      .rx_free_o(rx_free_o), .tx_avail_o(tx_avail_o),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .int_o(int_o)
   );

   always #5 PCLK = ~PCLK;

   int tests = 0;
   int fails = 0;

   // ---------------- reference model (behavioural, queue based) -------------
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   logic [2:0] m_ier;      // {elsi, etbei, erbfi}
   logic [7:0] m_lcr, m_scr, m_dll, m_dlm;
   logic       m_oe, m_arm;
   int         m_lvl;
   logic [7:0] dummy;

   task automatic model_reset();
      rxq.delete(); txq.delete();
      m_ier = 0; m_lcr = 0; m_scr = 0; m_dll = 0; m_dlm = 0;
      m_oe = 0; m_arm = 0; m_lvl = 1;
   endtask

   function automatic logic [7:0] model_iir();
      if (m_oe && m_ier[2])                              return 8'hC6;
      if (rxq.size() >= m_lvl && m_ier[0])               return 8'hC4;
      if (m_arm && txq.size() < DEPTH && m_ier[1])       return 8'hC2;
      return 8'hC1;
   endfunction

   function automatic logic [7:0] model_read(input logic [2:0] a);
      logic txnf;
      txnf = (txq.size() < DEPTH);
      case (a)
         3'd0: return m_lcr[7] ? m_dll : (rxq.size() > 0 ? rxq[0] : 8'h00);
         3'd1: return m_lcr[7] ? m_dlm : {5'b0, m_ier};
         3'd2: return model_iir();
         3'd3: return m_lcr;
         3'd4: return 8'h00;
         3'd5: return {1'b0, txnf, txnf, 3'b000, m_oe, rxq.size() > 0};
         3'd6: return 8'h0B;
         default: return m_scr;
      endcase
   endfunction

   // Apply one clock edge worth of activity to the model (pre-edge state in)
   task automatic model_step(input bit jv, input logic [7:0] jd, input bit jr,
                             input bit acc, input bit wr, input logic [2:0] a,
                             input logic [7:0] wd);
      int  rx_n, tx_n;
      bit  dlab, rbr_pop, thr_wr, fcr, iir_ack, rx_push, tx_pop, set_arm;
      rx_n    = rxq.size();
      tx_n    = txq.size();
      dlab    = m_lcr[7];
      rx_push = jv && (rx_n < DEPTH);
      tx_pop  = jr && (tx_n > 0);
      rbr_pop = acc && !wr && a == 0 && !dlab && rx_n > 0;
      thr_wr  = acc && wr && a == 0 && !dlab;
      fcr     = acc && wr && a == 2;
      iir_ack = acc && !wr && a == 2 && model_iir() == 8'hC2;
      set_arm = 0;
      // RX FIFO
      if (fcr && wd[1]) rxq.delete();
      else begin
         if (rbr_pop) void'(rxq.pop_front());
         if (rx_push) rxq.push_back(jd);
      end
      // TX FIFO
      if (fcr && wd[2]) txq.delete();
      else begin
         if (tx_pop) void'(txq.pop_front());
         if (thr_wr) begin
            if (tx_n == DEPTH) m_oe = 1;
            else txq.push_back(wd);
         end
         if (tx_pop && txq.size() == 0) set_arm = 1;
         if (thr_wr && txq.size() < DEPTH) set_arm = 1;
      end
      if (fcr && wd[2]) m_arm = 0;
      else if (set_arm) m_arm = 1;
      else if (iir_ack) m_arm = 0;
      if (acc && !wr && a == 5) m_oe = 0;
      if (acc && wr) begin
         case (a)
            3'd0: if (dlab) m_dll = wd;
            3'd1: if (dlab) m_dlm = wd; else m_ier = wd[2:0];
            3'd2: case (wd[7:6])
                     2'd0: m_lvl = 1;
                     2'd1: m_lvl = DEPTH / 4;
                     2'd2: m_lvl = DEPTH / 2;
                     default: m_lvl = DEPTH - 2;
                  endcase
            3'd3: m_lcr = wd;
            3'd7: m_scr = wd;
            default: ;
         endcase
      end
   endtask

   // ---------------- checking ----------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [7:0] iirv;
      iirv = model_iir();
      check("jrx_ready", jrx_ready_o, rxq.size() < DEPTH);
      check("jtx_valid", jtx_valid_o, txq.size() > 0);
      check("jtx_data", jtx_data_o, txq.size() > 0 ? txq[0] : 8'h00);
      check("rx_free", rx_free_o, DEPTH - rxq.size());
      check("tx_avail", tx_avail_o, txq.size());
      check("int_o", int_o, !iirv[0]);
   endtask

   task automatic idle_inputs();
      jrx_valid_i = 0; jrx_data_i = 0; jtx_ready_i = 0;
      PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
   endtask

   // One clock of stimulus; APB access is presented as a one-cycle acc phase
   task automatic cycle(input bit jv, input logic [7:0] jd, input bit jr,
                        input bit acc, input bit wr, input logic [2:0] a,
                        input logic [7:0] wd, output logic [7:0] rd);
      @(negedge PCLK);
      jrx_valid_i = jv; jrx_data_i = jd; jtx_ready_i = jr;
      PSEL = acc; PENABLE = acc; PWRITE = wr; PADDR = a; PWDATA = wd;
      #1;
      rd = PRDATA;
      if (acc && !wr) check("prdata", PRDATA, model_read(a));
      model_step(jv, jd, jr, acc, wr, a, wd);
      @(posedge PCLK);
      #1;
      idle_inputs();
      check_outputs();
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
      cycle(0, 0, 0, 1, 1, a, d, dummy);
   endtask
   task automatic rd_reg(input logic [2:0] a, output logic [7:0] r);
      cycle(0, 0, 0, 1, 0, a, 0, r);
   endtask
   task automatic jpush(input logic [7:0] d);
      cycle(1, d, 0, 0, 0, 0, 0, dummy);
   endtask
   task automatic jpop();
      cycle(0, 0, 1, 0, 0, 0, 0, dummy);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_jrx_ready"}, jrx_ready_o, 1);
      check({tag, "_jtx_valid"}, jtx_valid_o, 0);
      check({tag, "_jtx_data"}, jtx_data_o, 0);
      check({tag, "_rx_free"}, rx_free_o, DEPTH);
      check({tag, "_tx_avail"}, tx_avail_o, 0);
      check({tag, "_int"}, int_o, 0);
   endtask

   // ---------------- directed + random sequence -----------------------------
   logic [7:0] r;

   initial begin
      idle_inputs();
      model_reset();
      rst_i = 1;
      repeat (2) @(posedge PCLK);
      #1;
      check_reset_outputs("reset");
      PADDR = 3'd5; #1; check("reset_lsr", PRDATA, 8'h60);
      PADDR = 3'd2; #1; check("reset_iir", PRDATA, 8'hC1);
      PADDR = 3'd6; #1; check("reset_msr", PRDATA, 8'h0B);
      PADDR = 3'd3; #1; check("reset_lcr", PRDATA, 8'h00);
      PADDR = 3'd0;
      @(negedge PCLK);
      rst_i = 0;

      // Fill RX from JTAG, then drain over APB
      for (int i = 0; i < 8; i++) jpush(8'h41 + 8'(i));
      check("rx_full_ready", jrx_ready_o, 0);
      for (int i = 0; i < 8; i++) begin
         rd_reg(3'd0, r);
         check("rbr_order", r, 8'h41 + 8'(i));
      end
      rd_reg(3'd0, r);
      check("rbr_empty", r, 8'h00);
      rd_reg(3'd5, r);
      check("lsr_dr_clear", r[0], 0);

      // RX trigger level DEPTH/2
      wr_reg(3'd1, 8'h01);
      wr_reg(3'd2, 8'h80);
      for (int i = 0; i < 3; i++) begin
         jpush(8'h60 + 8'(i));
         check("trig_below", int_o, 0);
      end
      jpush(8'h63);
      check("trig_int", int_o, 1);
      rd_reg(3'd2, r);
      check("trig_iir", r, 8'hC4);
      rd_reg(3'd0, r);
      rd_reg(3'd2, r);
      check("trig_iir_after", r, 8'hC1);
      wr_reg(3'd2, 8'h02);

      // TX overrun
      wr_reg(3'd1, 8'h04);
      for (int i = 0; i < 8; i++) wr_reg(3'd0, 8'h10 + 8'(i));
      wr_reg(3'd0, 8'h99);
      check("ovr_tx_avail", tx_avail_o, 8);
      rd_reg(3'd2, r);
      check("ovr_iir", r, 8'hC6);
      rd_reg(3'd5, r);
      check("ovr_lsr", r, 8'h02);
      rd_reg(3'd5, r);
      check("ovr_lsr_cleared", r, 8'h00);
      for (int i = 0; i < 8; i++) begin
         check("ovr_drain_data", jtx_data_o, 8'h10 + 8'(i));
         jpop();
      end
      check("ovr_drained", jtx_valid_o, 0);

      // THR-empty interrupt and its acknowledge
      wr_reg(3'd1, 8'h02);
      wr_reg(3'd0, 8'h55);
      check("thr_valid", jtx_valid_o, 1);
      jpop();
      check("thr_avail", tx_avail_o, 0);
      rd_reg(3'd2, r);
      check("thr_iir", r, 8'hC2);
      rd_reg(3'd2, r);
      check("thr_iir_ack", r, 8'hC1);
      check("thr_int_low", int_o, 0);

      // Same-cycle push/pop, then FCR flush racing a push
      wr_reg(3'd1, 8'h00);
      for (int i = 0; i < 3; i++) jpush(8'hA1 + 8'(i));
      cycle(1, 8'hA4, 0, 1, 0, 3'd0, 0, r);
      check("pp_head", r, 8'hA1);
      check("pp_free", rx_free_o, DEPTH - 3);
      for (int i = 0; i < 3; i++) begin
         rd_reg(3'd0, r);
         check("pp_order", r, 8'hA2 + 8'(i));
      end
      wr_reg(3'd0, 8'h77);
      jpush(8'hB0);
      cycle(1, 8'hB1, 0, 1, 1, 3'd2, 8'h06, dummy);
      check("flush_rx", rx_free_o, DEPTH);
      check("flush_tx", tx_avail_o, 0);

      // Divisor latch access
      wr_reg(3'd3, 8'h80);
      wr_reg(3'd0, 8'h12);
      check("dll_tx_empty", tx_avail_o, 0);
      wr_reg(3'd1, 8'h34);
      rd_reg(3'd0, r);
      check("dll_read", r, 8'h12);
      rd_reg(3'd1, r);
      check("dlm_read", r, 8'h34);
      wr_reg(3'd3, 8'h03);
      rd_reg(3'd1, r);
      check("ier_untouched", r, 8'h00);

      // Randomized traffic against the model
      wr_reg(3'd1, 8'h07);
      wr_reg(3'd2, 8'h40);
      for (int n = 0; n < 400; n++) begin
         int op;
         logic [2:0] a;
         bit w;
         op = $urandom_range(0, 5);
         case (op)
            1: begin a = 3'd0; w = 0; end
            2: begin a = 3'd0; w = 1; end
            3: begin a = 3'd5; w = 0; end
            4: begin a = 3'd2; w = 0; end
            5: begin a = 3'd7; w = 1; end
            default: begin a = 3'd0; w = 0; end
         endcase
         cycle($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 3) == 0,
               op != 0, w, a, 8'($urandom), dummy);
      end

      // Asynchronous reset in the middle of traffic
      jpush(8'hC0);
      wr_reg(3'd0, 8'hD0);
      @(posedge PCLK);
      #2;
      rst_i = 1;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      @(negedge PCLK);
      rst_i = 0;
      rd_reg(3'd2, r);
      check("post_rst_iir", r, 8'hC1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
